spatz_xif_mem_responder: RTL

SPATZ_XIF_MEM_RESPONDER -- requirements
Module: spatz_xif_mem_responder

---
 rtl/spatz_xif_mem_responder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/spatz_xif_mem_responder.sv
// spatz_xif_mem_responder
// Bridges the Spatz VLSU X-interface memory port onto a simple req/gnt/rvalid
// memory bus. Aligned requests pass straight through and are tracked in an
// in-order ID FIFO. Misaligned requests are answered locally with an exception
// result, but only once every older request has returned, so results stay in order.
module spatz_xif_mem_responder #(
  parameter int unsigned NrOutstanding = 4,
  parameter int unsigned IdWidth       = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  // X-interface memory request
  input  logic               x_mem_valid_i,
  output logic               x_mem_ready_o,
  input  logic [IdWidth-1:0] x_mem_id_i,
  input  logic [31:0]        x_mem_addr_i,
  input  logic               x_mem_we_i,
  input  logic [1:0]         x_mem_size_i,
  input  logic [3:0]         x_mem_be_i,
  input  logic [31:0]        x_mem_wdata_i,
  output logic               x_mem_resp_exc_o,
  output logic [5:0]         x_mem_resp_exccode_o,
  // Memory-side request
  output logic               mem_req_o,
  output logic [31:0]        mem_addr_o,
  output logic               mem_we_o,
  output logic [3:0]         mem_be_o,
  output logic [31:0]        mem_wdata_o,
  input  logic               mem_gnt_i,
  // Memory-side in-order response
  input  logic               mem_rvalid_i,
  input  logic [31:0]        mem_rdata_i,
  input  logic               mem_err_i,
  // X-interface memory result (always consumed)
  output logic               x_mem_result_valid_o,
  output logic [IdWidth-1:0] x_mem_result_id_o,
  output logic [31:0]        x_mem_result_rdata_o,
  output logic               x_mem_result_err_o
);

  localparam int unsigned          PtrWidth = $clog2(NrOutstanding);
  localparam int unsigned          CntWidth = PtrWidth + 1;
  localparam logic [CntWidth-1:0]  MaxCnt   = CntWidth'(NrOutstanding);
  localparam logic [5:0]           ExcLoadMisaligned  = 6'd4;
  localparam logic [5:0]           ExcStoreMisaligned = 6'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_ERR
  } state_e;

  // One FIFO entry per granted request: the ID to return and whether it was
  // a store (stores return zero read data).
  typedef struct packed {
    logic               we;
    logic [IdWidth-1:0] id;
  } entry_t;

  state_e              r_state;
  state_e              w_state_next;
  logic [CntWidth-1:0] r_cnt;
  logic [PtrWidth-1:0] r_wptr;
  logic [PtrWidth-1:0] r_rptr;
  entry_t              r_fifo [NrOutstanding];
  entry_t              w_head;

  logic                w_misaligned;
  logic                w_cnt_full;
  logic                w_cnt_zero;
  logic                w_grant;
  logic                w_rsp_pop;
  logic                w_err_acc;

  logic                r_res_valid;
  logic [IdWidth-1:0]  r_res_id;
  logic [31:0]         r_res_rdata;
  logic                r_res_err;

  // Alignment check: size 3 is never legal.
  assign w_misaligned = (x_mem_size_i == 2'd3)
                     || ((x_mem_size_i == 2'd1) && x_mem_addr_i[0])
                     || ((x_mem_size_i == 2'd2) && (x_mem_addr_i[1:0] != 2'b00));

  assign w_cnt_full = (r_cnt == MaxCnt);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_grant    = mem_req_o && mem_gnt_i;
  // A response with nothing outstanding is stray and is dropped.
  assign w_rsp_pop  = mem_rvalid_i && !w_cnt_zero;
  assign w_head     = r_fifo[r_rptr];

  assign mem_addr_o  = x_mem_addr_i;
  assign mem_we_o    = x_mem_we_i;
  assign mem_be_o    = x_mem_be_i;
  assign mem_wdata_o = x_mem_wdata_i;

  assign x_mem_resp_exc_o     = w_err_acc;
  assign x_mem_resp_exccode_o = !w_err_acc ? 6'd0
                              : (x_mem_we_i ? ExcStoreMisaligned : ExcLoadMisaligned);

  assign x_mem_result_valid_o = r_res_valid;
  assign x_mem_result_id_o    = r_res_id;
  assign x_mem_result_rdata_o = r_res_rdata;
  assign x_mem_result_err_o   = r_res_err;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic: misaligned requests wait in DRAIN until nothing is outstanding.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (x_mem_valid_i && w_misaligned)
          w_state_next = w_cnt_zero ? S_ERR : S_DRAIN;
      end
      S_DRAIN: begin
        if (w_cnt_zero)
          w_state_next = (x_mem_valid_i && w_misaligned) ? S_ERR : S_IDLE;
      end
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: handshake and memory request, all held low during reset.
  always_comb begin
    mem_req_o     = 1'b0;
    x_mem_ready_o = 1'b0;
    w_err_acc     = 1'b0;
    if (rst_ni) begin
      unique case (r_state)
        S_IDLE: begin
          if (x_mem_valid_i && !w_misaligned) begin
            mem_req_o     = !w_cnt_full;
            x_mem_ready_o = !w_cnt_full && mem_gnt_i;
          end else if (x_mem_valid_i && w_cnt_zero) begin
            w_err_acc     = 1'b1;
            x_mem_ready_o = 1'b1;
          end
        end
        S_DRAIN: begin
          if (x_mem_valid_i && w_misaligned && w_cnt_zero) begin
            w_err_acc     = 1'b1;
            x_mem_ready_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outstanding counter: a grant and a response in the same cycle cancel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      unique case ({w_grant, w_rsp_pop})
        2'b10:   r_cnt <= r_cnt + CntWidth'(1);
        2'b01:   r_cnt <= r_cnt - CntWidth'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ID FIFO pointers; depth is a power of two so they wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_grant)   r_wptr <= r_wptr + PtrWidth'(1);
      if (w_rsp_pop) r_rptr <= r_rptr + PtrWidth'(1);
    end
  end

  // ID FIFO storage.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; the pointers and counter
    // define which entries are live, so stale contents are never read.
    if (w_grant) r_fifo[r_wptr] <= '{we: x_mem_we_i, id: x_mem_id_i};
  end

  // Result register: memory responses and misaligned-error results are
  // mutually exclusive (one needs cnt>0, the other cnt=0).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_rdata <= '0;
      r_res_err   <= 1'b0;
    end else if (w_rsp_pop) begin
      r_res_valid <= 1'b1;
      r_res_id    <= w_head.id;
      r_res_rdata <= w_head.we ? 32'd0 : mem_rdata_i;
      r_res_err   <= mem_err_i;
    end else if (w_err_acc) begin
      r_res_valid <= 1'b1;
      r_res_id    <= x_mem_id_i;
      r_res_rdata <= 32'd0;
      r_res_err   <= 1'b1;
    end else begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_rdata <= '0;
      r_res_err   <= 1'b0;
    end
  end

endmodule
